// File: rtl/matmul_seq.sv
// Instruction sequencer emitting the MIPS-subset stream for C = A x B.
// Optional abort input enabled by defining MATMUL_SEQ_ABORT_EN.
module matmul_seq #(
  parameter int N      = 3,
  parameter int A_BASE = 0,
  parameter int B_BASE = 9,
  parameter int C_BASE = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        instr_ready,
`ifdef MATMUL_SEQ_ABORT_EN
  input  logic        abort,
`endif
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        busy,
  output logic        done,
  output logic [3:0]  row_idx,
  output logic [3:0]  col_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LDA, S_LDB,
    S_MUL, S_ACC, S_STR, S_DONE
  } state_e;

  localparam logic [3:0]  NM1 = 4'(N - 1);
  localparam logic [15:0] NW  = 16'(N);

  state_e      state_q, state_d;
  logic [3:0]  i_q, i_d;
  logic [3:0]  j_q, j_d;
  logic [3:0]  k_q, k_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic        hs;

  assign hs = valid_q & instr_ready;

  function automatic logic [31:0] enc(
    input state_e     s,
    input logic [3:0] i,
    input logic [3:0] j,
    input logic [3:0] k
  );
    logic [15:0] a_adr;
    logic [15:0] b_adr;
    logic [15:0] c_adr;
    a_adr = 16'(A_BASE) + 16'(i) * NW + 16'(k);
    b_adr = 16'(B_BASE) + 16'(k) * NW + 16'(j);
    c_adr = 16'(C_BASE) + 16'(i) * NW + 16'(j);
    enc   = '0;
    case (s)
      S_CLR: enc = {6'b001000, 5'd23, 5'd19, 16'd0};
      S_LDA: enc = {6'b100011, 5'd23, 5'd16, a_adr};
      S_LDB: enc = {6'b100011, 5'd23, 5'd17, b_adr};
      S_MUL: enc = {6'b000000, 5'd16, 5'd17, 5'd18,
                    5'd0, 6'b011000};
      S_ACC: enc = {6'b000000, 5'd18, 5'd19, 5'd19,
                    5'd0, 6'b100000};
      S_STR: enc = {6'b101011, 5'd23, 5'd19, c_adr};
      default: enc = '0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_CLR;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      S_CLR: if (hs) begin
        state_d = S_LDA;
        k_d     = '0;
      end
      S_LDA: if (hs) state_d = S_LDB;
      S_LDB: if (hs) state_d = S_MUL;
      S_MUL: if (hs) state_d = S_ACC;
      S_ACC: if (hs) begin
        if (k_q == NM1) begin
          state_d = S_STR;
        end else begin
          state_d = S_LDA;
          k_d     = k_q + 4'd1;
        end
      end
      S_STR: if (hs) begin
        state_d = S_CLR;
        if (j_q == NM1) begin
          j_d = '0;
          if (i_q == NM1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            i_d     = '0;
          end else begin
            i_d = i_q + 4'd1;
          end
        end else begin
          j_d = j_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef MATMUL_SEQ_ABORT_EN
    // Abort wins over a handshake in the same cycle.
    if (abort && valid_q) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end
`endif
    valid_d = (state_d != S_IDLE) && (state_d != S_DONE);
    instr_d = enc(state_d, i_d, j_d, k_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign busy        = valid_q;
  assign done        = done_q;
  assign row_idx     = i_q;
  assign col_idx     = j_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Scoreboard bench for matmul_seq with a small datapath model.
// Abort steps are compiled in when MATMUL_SEQ_ABORT_EN is defined.
module tb_matmul_seq;

  localparam int N   = 3;
  localparam int AB  = 0;
  localparam int BB  = 9;
  localparam int CB  = 18;
  localparam int TOT = N * N * (4 * N + 2);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        instr_ready = 1'b0;
`ifdef MATMUL_SEQ_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic [31:0] instr;
  logic        instr_valid;
  logic        busy;
  logic        done;
  logic [3:0]  row_idx;
  logic [3:0]  col_idx;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];
  int          regs[32];
  int          mem[64];

  always #5 clk = ~clk;

  matmul_seq #(
    .N(N), .A_BASE(AB), .B_BASE(BB), .C_BASE(CB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .instr_ready(instr_ready),
`ifdef MATMUL_SEQ_ABORT_EN
    .abort(abort),
`endif
    .instr(instr),
    .instr_valid(instr_valid),
    .busy(busy),
    .done(done),
    .row_idx(row_idx),
    .col_idx(col_idx)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        sb.push_back(32'h22F30000);
        for (int k = 0; k < N; k++) begin
          sb.push_back(32'h8EF00000 | 32'(AB + i * N + k));
          sb.push_back(32'h8EF10000 | 32'(BB + k * N + j));
          sb.push_back(32'h02119018);
          sb.push_back(32'h02539820);
        end
        sb.push_back(32'hAEF30000 | 32'(CB + i * N + j));
      end
  endtask

  task automatic exec(input logic [31:0] w);
    int rs;
    int rt;
    int rd;
    int imm;
    rs  = int'(w[25:21]);
    rt  = int'(w[20:16]);
    rd  = int'(w[15:11]);
    imm = int'(w[15:0]);
    case (w[31:26])
      6'h08: regs[rt] = regs[rs] + imm;
      6'h23: regs[rt] = mem[imm % 64];
      6'h2B: mem[imm % 64] = regs[rt];
      6'h00: begin
        if (w[5:0] == 6'h18) regs[rd] = regs[rs] * regs[rt];
        if (w[5:0] == 6'h20) regs[rd] = regs[rs] + regs[rt];
      end
      default: ;
    endcase
  endtask

  task automatic do_start();
    start = 1'b1;
    push_run();
    step();
    start = 1'b0;
  endtask

  task automatic run(input int stall, input int brk,
                     output int nhs, output int dcyc,
                     output bit dseen);
    logic [31:0] prev;
    bit          pst;
    int          cyc;
    nhs   = 0;
    dcyc  = 0;
    dseen = 1'b0;
    pst   = 1'b0;
    prev  = '0;
    cyc   = 1;
    while (cyc < 3000) begin
      instr_ready = ($urandom_range(99) >= stall);
      if (pst) chk("stall_hold", instr, prev);
      if (instr_valid && instr_ready) begin
        nhs++;
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) chk("instr", instr, sb.pop_front());
        exec(instr);
      end
      pst  = instr_valid && !instr_ready;
      prev = instr;
      step();
      cyc++;
      if (done) begin
        dseen = 1'b1;
        dcyc  = cyc;
        break;
      end
      if (brk != 0 && nhs == brk) break;
    end
    instr_ready = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_valid"}, 32'(instr_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_row"}, 32'(row_idx), 0);
    chk({tag, "_col"}, 32'(col_idx), 0);
  endtask

  initial begin
    int          nhs;
    int          dcyc;
    bit          ds;
    int          sum;
    logic [31:0] hold;

    step();
    step();
    chk_reset("rst");
    rst_n = 1'b1;
    step();

    for (int a = 0; a < 64; a++) mem[a] = 0;
    for (int a = 0; a < 32; a++) regs[a] = 0;
    for (int a = 0; a < N * N; a++) begin
      mem[AB + a] = a + 1;
      mem[BB + a] = a + 10;
    end

    do_start();
    chk("first_busy", 32'(busy), 1);
    chk("first_row", 32'(row_idx), 0);
    chk("first_col", 32'(col_idx), 0);
    run(0, 0, nhs, dcyc, ds);
    chk("full_done_seen", 32'(ds), 1);
    chk("full_hs_count", nhs, TOT);
    chk("full_done_cycle", dcyc, 127);
    chk("full_busy_at_done", 32'(busy), 0);
    chk("full_valid_at_done", 32'(instr_valid), 0);
    chk("full_sb_empty", sb.size(), 0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        sum = 0;
        for (int k = 0; k < N; k++)
          sum += (i * N + k + 1) * (k * N + j + 10);
        chk("c_elem", mem[CB + i * N + j], sum);
      end
    chk("c00", mem[CB], 84);
    chk("c20", mem[CB + 6], 318);
    chk("c22", mem[CB + 8], 366);

    do_start();
    chk("b2b_done_pulse", 32'(done), 0);
    chk("b2b_busy", 32'(busy), 1);
    run(0, 0, nhs, dcyc, ds);
    chk("b2b_done_seen", 32'(ds), 1);
    chk("b2b_hs_count", nhs, TOT);
    step();
    chk("b2b_done_drop", 32'(done), 0);

    do_start();
    run(50, 0, nhs, dcyc, ds);
    chk("stall_done_seen", 32'(ds), 1);
    chk("stall_hs_count", nhs, TOT);
    chk("stall_sb_empty", sb.size(), 0);
    step();

    do_start();
    run(0, 10, nhs, dcyc, ds);
    hold = instr;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_instr", instr, hold);
    chk("busy_start_busy", 32'(busy), 1);
    chk("busy_start_col", 32'(col_idx), 0);
    run(0, 0, nhs, dcyc, ds);
    chk("busy_start_hs", nhs, TOT - 10);
    chk("busy_start_sb", sb.size(), 0);
    step();

    do_start();
    run(50, 40, nhs, dcyc, ds);
    chk("rst_hs_count", nhs, 40);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    sb.delete();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_done", 32'(done), 0);
    do_start();
    chk("restart_instr", instr, 32'h22F30000);
    chk("restart_row", 32'(row_idx), 0);
    chk("restart_col", 32'(col_idx), 0);
    run(0, 0, nhs, dcyc, ds);
    chk("restart_hs", nhs, TOT);
    step();

`ifdef MATMUL_SEQ_ABORT_EN
    do_start();
    run(0, 20, nhs, dcyc, ds);
    abort = 1'b1;
    instr_ready = 1'b1;
    step();
    abort = 1'b0;
    instr_ready = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(instr_valid), 0);
    chk("abort_done", 32'(done), 0);
    step();
    chk("abort_done_later", 32'(done), 0);
    sb.delete();
    do_start();
    run(0, 0, nhs, dcyc, ds);
    chk("abort_rerun_hs", nhs, TOT);
    chk("abort_rerun_done", 32'(ds), 1);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
